// File: rtl/pet2001_char_pixel_pipe.sv
// PET 2001 character/pixel pipeline.
// Takes the CRTC-style outputs of the discrete video timing generator and
// produces the character pixel stream. The pipeline has three steps:
//   1. fetch the screen code from video RAM
//   2. look up the glyph row in the character ROM
//   3. load the row into an 8-bit shifter, which emits it MSB first at the
//      pixel rate
// Blank and sync are delayed by the same number of character slots so they
// stay aligned with the pixels for the scaler and video mixer.
//
// PIPE_DEPTH is the number of ce_1m slots between an address and its pixel
// load. The fetch/lookup structure below is built for a depth of 2 only. The
// parameter sizes the timing delay line so both paths visibly share it.

module pet2001_char_pixel_pipe #(
  parameter int PIPE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce_1m,
  input  logic        ce_8m,
  input  logic [9:0]  vid_ma,
  input  logic [4:0]  vid_ra,
  input  logic        vid_de,
  input  logic        vid_hblank,
  input  logic        vid_vblank,
  input  logic        vid_hsync,
  input  logic        vid_vsync,
  input  logic        video_blank,
  input  logic        video_gfx,
  output logic [9:0]  vram_addr,
  input  logic [7:0]  vram_data,
  output logic [10:0] charrom_addr,
  input  logic [7:0]  charrom_data,
  output logic        pix,
  output logic        pix_hblank,
  output logic        pix_vblank,
  output logic        pix_hsync,
  output logic        pix_vsync
);

  // Timing bundle carried alongside the character data.
  typedef struct packed {
    logic hblank;
    logic vblank;
    logic hsync;
    logic vsync;
  } timing_t;

  // Stage 0 state: address phase.
  logic       de1;
  logic [2:0] ra1;

  // Stage 1 state: glyph lookup phase.
  logic       inv2;
  logic       de2;

  // Stage 2 state: pixel shifter and aligned timing.
  logic [7:0] shreg;
  timing_t    t_pipe [PIPE_DEPTH];
  timing_t    t_out;

  // Glyph row as it will be loaded into the shifter.
  logic [7:0] glyph_row;
  logic [7:0] load_byte;

  timing_t    t_in;

  assign t_in = '{hblank: vid_hblank, vblank: vid_vblank,
                  hsync:  vid_hsync,  vsync:  vid_vsync};

  // Stage 0: present the matrix address to video RAM and capture the row
  // information. Raster rows 8..31 lie below the 8-line glyph and count as
  // blank rows.
  always_ff @(posedge clk) begin
    // NOTE: every clocked register uses non-blocking assignment so that all
    // stages read the values from before this edge, giving true pipelining.
    if (reset) begin
      vram_addr <= '0;
      de1       <= 1'b0;
      ra1       <= '0;
    end else if (ce_1m) begin
      vram_addr <= vid_ma;
      de1       <= vid_de & (vid_ra[4:3] == 2'b00);
      ra1       <= vid_ra[2:0];
    end
  end

  // Stage 1: the screen code has arrived from RAM. Form the ROM address
  // from it and keep the reverse-video bit for the next slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      charrom_addr <= '0;
      inv2         <= 1'b0;
      de2          <= 1'b0;
    end else if (ce_1m) begin
      charrom_addr <= {video_gfx, vram_data[6:0], ra1};
      inv2         <= vram_data[7];
      de2          <= de2_next();
    end
  end

  // de passes through stage 1 unchanged. It is kept as a function so that
  // the stage-1 block reads as a pure list of register loads.
  function automatic logic de2_next();
    return de1;
  endfunction

  // Glyph row after reverse video. Inversion is applied only inside the
  // displayed area, so borders and blanked rows never show an inverted fill.
  always_comb begin
    glyph_row = charrom_data ^ {8{inv2}};
    load_byte = 8'h00;
    if (de2 && !video_blank) begin
      load_byte = glyph_row;
    end
  end

  // Stage 2 shifter: load a new row on ce_1m, otherwise shift left on each
  // ce_8m. On the coincident ce_8m the load takes priority and no shift
  // happens, so bit 7 of the new row is the first pixel of the character.
  // Once the row is exhausted the shifter keeps filling with zeros.
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg <= 8'h00;
    end else if (ce_1m) begin
      shreg <= load_byte;
    end else if (ce_8m) begin
      shreg <= {shreg[6:0], 1'b0};
    end
  end

  assign pix = shreg[7];

  // Timing delay line: the same number of character slots as the data path,
  // followed by an output register that updates on the same edge as the
  // shifter load.
  always_ff @(posedge clk) begin
    // NOTE: the delay line is a small register array, not a RAM, so it is
    // cleared element by element on reset like any other flop.
    if (reset) begin
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        t_pipe[i] <= '0;
      end
      t_out <= '0;
    end else if (ce_1m) begin
      t_pipe[0] <= t_in;
      for (int i = 1; i < PIPE_DEPTH; i++) begin
        t_pipe[i] <= t_pipe[i-1];
      end
      t_out <= t_pipe[PIPE_DEPTH-1];
    end
  end

  assign pix_hblank = t_out.hblank;
  assign pix_vblank = t_out.vblank;
  assign pix_hsync  = t_out.hsync;
  assign pix_vsync  = t_out.vsync;

endmodule

// File: tb/tb_pet2001_char_pixel_pipe.sv
// Self-checking bench for pet2001_char_pixel_pipe.
// The reference model keeps a history of every ce_1m slot's inputs. From
// that history it states what each output must show: the pixel of slot n
// comes from the address of slot n-2, and is emitted MSB first over the
// eight ce_8m pulses of that slot.

module tb_pet2001_char_pixel_pipe;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ce_1m = 1'b0;
  logic        ce_8m = 1'b0;
  logic [9:0]  vid_ma = '0;
  logic [4:0]  vid_ra = '0;
  logic        vid_de = 1'b1;
  logic        vid_hblank = 1'b0;
  logic        vid_vblank = 1'b0;
  logic        vid_hsync = 1'b0;
  logic        vid_vsync = 1'b0;
  logic        video_blank = 1'b0;
  logic        video_gfx = 1'b0;
  logic [9:0]  vram_addr;
  logic [7:0]  vram_data;
  logic [10:0] charrom_addr;
  logic [7:0]  charrom_data;
  logic        pix;
  logic        pix_hblank;
  logic        pix_vblank;
  logic        pix_hsync;
  logic        pix_vsync;

  logic [7:0]  vram [1024];
  logic [7:0]  rom  [2048];

  int total = 0;
  int bad   = 0;

  pet2001_char_pixel_pipe #(.PIPE_DEPTH(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .ce_1m        (ce_1m),
    .ce_8m        (ce_8m),
    .vid_ma       (vid_ma),
    .vid_ra       (vid_ra),
    .vid_de       (vid_de),
    .vid_hblank   (vid_hblank),
    .vid_vblank   (vid_vblank),
    .vid_hsync    (vid_hsync),
    .vid_vsync    (vid_vsync),
    .video_blank  (video_blank),
    .video_gfx    (video_gfx),
    .vram_addr    (vram_addr),
    .vram_data    (vram_data),
    .charrom_addr (charrom_addr),
    .charrom_data (charrom_data),
    .pix          (pix),
    .pix_hblank   (pix_hblank),
    .pix_vblank   (pix_vblank),
    .pix_hsync    (pix_hsync),
    .pix_vsync    (pix_vsync)
  );

  always #5 clk = ~clk;

  // Clock enables: ce_8m every 2 clk, ce_1m every 16 clk on a ce_8m.
  // While hold_1m is set, the ce_1m pulses are dropped.
  int unsigned ce_cnt = 0;
  logic        hold_1m = 1'b0;
  always @(negedge clk) begin
    ce_8m = (ce_cnt % 2) == 0;
    ce_1m = ((ce_cnt % 16) == 0) && !hold_1m;
    ce_cnt++;
  end

  // Synchronous memories with a read latency of one clk.
  always @(posedge clk) begin
    vram_data    <= vram[vram_addr];
    charrom_data <= rom[charrom_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [9:0]  h_ma    [4096];
  logic [4:0]  h_ra    [4096];
  logic        h_de    [4096];
  logic [3:0]  h_t     [4096];
  logic        h_gfx   [4096];
  int          n = 0;
  int          p = 8;
  logic [7:0]  exp_byte = '0;
  logic [3:0]  exp_t = '0;
  logic [9:0]  exp_vaddr = '0;
  logic [10:0] exp_caddr = '0;
  bit          check_en = 1'b0;

  always @(posedge clk) begin
    logic [7:0] prev_code;
    logic [2:0] prev_row;
    logic [7:0] code;
    int         e;
    if (reset) begin
      n = 0; p = 8; exp_byte = '0; exp_t = '0;
      exp_vaddr = '0; exp_caddr = '0; check_en = 1'b1;
    end else if (check_en && ce_1m) begin
      h_ma[n]  = vid_ma;
      h_ra[n]  = vid_ra;
      h_de[n]  = vid_de;
      h_t[n]   = {vid_hblank, vid_vblank, vid_hsync, vid_vsync};
      h_gfx[n] = video_gfx;
      exp_vaddr = vid_ma;
      prev_code = (n >= 1) ? vram[h_ma[n-1]] : vram[0];
      prev_row  = (n >= 1) ? h_ra[n-1][2:0] : 3'd0;
      exp_caddr = {video_gfx, prev_code[6:0], prev_row};
      if (n >= 2) begin
        e    = n - 2;
        code = vram[h_ma[e]];
        if (h_de[e] && h_ra[e] < 5'd8 && !video_blank)
          exp_byte = rom[{h_gfx[n-1], code[6:0], h_ra[e][2:0]}] ^ {8{code[7]}};
        else
          exp_byte = 8'h00;
        exp_t = h_t[e];
      end else begin
        exp_byte = 8'h00;
        exp_t    = 4'h0;
      end
      p = 0;
      if (n < 4095) n++;
    end else if (check_en && ce_8m) begin
      p++;
    end
  end

  // Compare process: outputs are stable at the falling edge.
  always @(negedge clk) begin
    if (check_en) begin
      check("vram_addr", 32'(vram_addr), 32'(exp_vaddr));
      check("charrom_addr", 32'(charrom_addr), 32'(exp_caddr));
      check("pix", 32'(pix), (p < 8) ? 32'(exp_byte[7-p]) : 32'd0);
      check("timing", 32'({pix_hblank, pix_vblank, pix_hsync, pix_vsync}), 32'(exp_t));
    end
  end

  // ---------------- helpers ----------------
  task automatic wait_ce1m();
    bit ok = 1'b0;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(posedge clk);
      ok = ce_1m;
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL wait_ce1m: got timeout want ce_1m pulse");
    end
  endtask

  task automatic wait_ce8m();
    bit ok = 1'b0;
    for (int i = 0; i < 16 && !ok; i++) begin
      @(posedge clk);
      ok = ce_8m;
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL wait_ce8m: got timeout want ce_8m pulse");
    end
  endtask

  // Called right after a ce_1m edge; gathers the 8 pixels of that slot.
  task automatic collect(output logic [7:0] b);
    b = 8'h00;
    #1 b = {b[6:0], pix};
    for (int i = 1; i < 8; i++) begin
      wait_ce8m();
      #1 b = {b[6:0], pix};
    end
  endtask

  // Inputs set beforehand are captured at the first edge. The character
  // they select is loaded two edges later and then collected.
  task automatic char_after(output logic [7:0] b);
    wait_ce1m();
    wait_ce1m();
    wait_ce1m();
    collect(b);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] b;
    logic [9:0] hs;
    for (int i = 0; i < 1024; i++) vram[i] = 8'($urandom);
    for (int i = 0; i < 2048; i++) rom[i]  = 8'($urandom);
    vram[0]       = 8'h01;
    vram[5]       = 8'h81;
    rom[11'h008]  = 8'b0011_1100;
    rom[11'h009]  = 8'hFF;

    // Reset held with enables running.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", 32'({vram_addr, charrom_addr, pix, pix_hblank,
                                pix_vblank, pix_hsync, pix_vsync}), 32'd0);
    reset = 1'b0;

    // Normal glyph right out of reset: ma=0, ra=0.
    wait_ce1m();
    #1 check("edge0_pix", 32'(pix), 32'd0);
    check("edge0_vram_addr", 32'(vram_addr), 32'd0);
    wait_ce1m();
    #1 check("edge1_pix", 32'(pix), 32'd0);
    check("edge1_charrom_addr", 32'(charrom_addr), 32'h008);
    wait_ce1m();
    collect(b);
    check("glyph_normal", 32'(b), 32'h3C);

    // Reverse video.
    @(negedge clk); vid_ma = 10'd5;
    char_after(b);
    check("glyph_reverse", 32'(b), 32'hC3);

    // Reverse data outside display enable.
    @(negedge clk); vid_de = 1'b0;
    char_after(b);
    check("glyph_de_off", 32'(b), 32'h00);

    // Whole-display blank.
    @(negedge clk); vid_de = 1'b1; video_blank = 1'b1;
    char_after(b);
    check("glyph_video_blank", 32'(b), 32'h00);

    // Raster row 9 is a blank row even with de.
    @(negedge clk); video_blank = 1'b0; vid_ra = 5'd9;
    char_after(b);
    check("glyph_row9", 32'(b), 32'h00);

    // Character set select goes to the ROM address MSB.
    @(negedge clk); vid_ra = 5'd0; vid_ma = 10'd0; video_gfx = 1'b1;
    wait_ce1m();
    wait_ce1m();
    #1 check("gfx_charrom_addr", 32'(charrom_addr), 32'h408);
    @(negedge clk); video_gfx = 1'b0;

    // hsync pulse of 4 slots, seen 2 slots later for exactly 4 slots.
    @(negedge clk); vid_hsync = 1'b1;
    hs = '0;
    for (int i = 0; i < 10; i++) begin
      wait_ce1m();
      #1 hs[i] = pix_hsync;
      if (i == 3) begin
        @(negedge clk); vid_hsync = 1'b0;
      end
    end
    check("hsync_alignment", 32'(hs), 32'h03C);

    // 40 back-to-back characters: continuous pixel stream.
    @(negedge clk); vid_ma = 10'd0; vid_ra = 5'd3; vid_de = 1'b1;
    for (int k = 1; k < 40; k++) begin
      wait_ce1m();
      @(negedge clk); vid_ma = 10'(k);
    end

    // Randomised slots, with mid-line resets and missing ce_1m pulses.
    for (int it = 0; it < 200; it++) begin
      wait_ce1m();
      @(negedge clk);
      vid_ma     = 10'($urandom);
      vid_ra     = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(8, 31))
                                               : 5'($urandom_range(0, 7));
      vid_de     = ($urandom_range(0, 7) != 0);
      vid_hblank = 1'($urandom);
      vid_vblank = 1'($urandom);
      vid_hsync  = 1'($urandom);
      vid_vsync  = 1'($urandom);
      if ($urandom_range(0, 3) == 0) video_gfx = ~video_gfx;
      video_blank = ($urandom_range(0, 7) == 0);
      if (it % 50 == 25) begin
        repeat (5) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
      end
      if (it % 40 == 10) begin
        hold_1m = 1'b1;
        repeat (16) @(negedge clk);
        hold_1m = 1'b0;
      end
    end

    repeat (3) wait_ce1m();
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want test end");
    $fatal(1, "watchdog");
  end

endmodule
